// File: rtl/ascon_mem_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ascon_mem_sched: fetches AD/PT into the ASCON wrapper and writes CT+tag back.
// Revision 1.0
// ----------------------------------------------------------------------------
module ascon_mem_sched #(
    parameter int BUF_DEPTH = 4,
    parameter int BLK_AD_AW = 3,
    parameter int BLK_PT_AW = 3,
    parameter int MEM_AW    = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    cmd_start_i,
    input  logic [MEM_AW-1:0]       src_base_i,
    input  logic [MEM_AW-1:0]       dst_base_i,
    input  logic [BLK_AD_AW-1:0]    ad_size_i,
    input  logic [BLK_PT_AW-1:0]    pt_size_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [MEM_AW-1:0]       mem_addr_o,
    output logic [63:0]             mem_wdata_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [63:0]             mem_rdata_i,
    output logic [BUF_DEPTH*64-1:0] asc_data_o,
    output logic                    asc_start_o,
    output logic                    asc_data_valid_o,
    output logic                    asc_ct_read_ack_o,
    input  logic                    asc_data_req_i,
    input  logic                    asc_ct_ready_i,
    input  logic                    asc_done_i,
    input  logic [BUF_DEPTH*64-1:0] asc_ct_i,
    input  logic [127:0]            asc_tag_i
);

    localparam int IDX_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int RS_W  = ((BLK_AD_AW > BLK_PT_AW) ? BLK_AD_AW : BLK_PT_AW) + 1;

    localparam logic [MEM_AW-1:0]    A_ONE    = MEM_AW'(1);
    localparam logic [RS_W-1:0]      RS_ONE   = RS_W'(1);
    localparam logic [BLK_PT_AW-1:0] PT_ONE   = BLK_PT_AW'(1);
    localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(BUF_DEPTH);
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(BUF_DEPTH - 1);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_FILL  = 4'd1;
    localparam logic [3:0] S_KICK  = 4'd2;
    localparam logic [3:0] S_RUN   = 4'd3;
    localparam logic [3:0] S_FEED  = 4'd4;
    localparam logic [3:0] S_GUARD = 4'd5;
    localparam logic [3:0] S_DRAIN = 4'd6;
    localparam logic [3:0] S_ACK   = 4'd7;
    localparam logic [3:0] S_TAIL  = 4'd8;
    localparam logic [3:0] S_TAG0  = 4'd9;
    localparam logic [3:0] S_TAG1  = 4'd10;
    localparam logic [3:0] S_DONE  = 4'd11;

    logic [3:0]           state;
    logic [IDX_W-1:0]     fill_idx;
    logic [CNT_W-1:0]     wr_idx;
    logic [CNT_W-1:0]     cnt;
    logic [MEM_AW-1:0]    src_ptr;
    logic [MEM_AW-1:0]    dst_ptr;
    logic [RS_W-1:0]      rem_src;
    logic [BLK_PT_AW-1:0] rem_ct;
    logic                 rd_pend;
    logic                 refill;
    logic                 err;
    logic [63:0]          buf_q [BUF_DEPTH];
    logic [63:0]          ct_w  [BUF_DEPTH];

    logic fill_rd;
    logic slot_done;
    logic wr_ct;
    logic wr_tag;

    for (genvar i = 0; i < BUF_DEPTH; i++) begin : g_slots
        assign asc_data_o[i*64 +: 64] = buf_q[i];
        assign ct_w[i]                = asc_ct_i[i*64 +: 64];
    end

    // A slot is finished either by read data arriving or, once the source is
    // exhausted, immediately as a zero word without touching memory.
    assign fill_rd   = (state == S_FILL) && !rd_pend && (rem_src != '0);
    assign slot_done = (state == S_FILL) && (rd_pend ? mem_rvalid_i : (rem_src == '0));
    assign wr_ct     = ((state == S_DRAIN) || (state == S_TAIL)) && (wr_idx != cnt);
    assign wr_tag    = (state == S_TAG0) || (state == S_TAG1);

    assign mem_req_o         = fill_rd | wr_ct | wr_tag;
    assign mem_we_o          = wr_ct | wr_tag;
    assign busy_o            = (state != S_IDLE);
    assign done_o            = (state == S_DONE);
    assign err_o             = err;
    assign asc_start_o       = (state == S_KICK);
    assign asc_data_valid_o  = (state == S_FEED);
    assign asc_ct_read_ack_o = (state == S_ACK);

    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (fill_rd) begin
            mem_addr_o = src_ptr;
        end else if (wr_ct) begin
            mem_addr_o  = dst_ptr;
            mem_wdata_o = ct_w[wr_idx[IDX_W-1:0]];
        end else if (state == S_TAG0) begin
            mem_addr_o  = dst_ptr;
            mem_wdata_o = asc_tag_i[63:0];
        end else if (state == S_TAG1) begin
            mem_addr_o  = dst_ptr;
            mem_wdata_o = asc_tag_i[127:64];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state    <= S_IDLE;
            fill_idx <= '0;
            wr_idx   <= '0;
            cnt      <= '0;
            src_ptr  <= '0;
            dst_ptr  <= '0;
            rem_src  <= '0;
            rem_ct   <= '0;
            rd_pend  <= 1'b0;
            refill   <= 1'b0;
            err      <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
        end else begin
            case (state)
                S_IDLE: if (cmd_start_i) begin
                    state    <= S_FILL;
                    src_ptr  <= src_base_i;
                    dst_ptr  <= dst_base_i;
                    rem_src  <= RS_W'(ad_size_i) + RS_W'(pt_size_i);
                    rem_ct   <= pt_size_i;
                    fill_idx <= '0;
                    rd_pend  <= 1'b0;
                    refill   <= 1'b0;
                    err      <= 1'b0;
                end
                S_FILL: begin
                    if (fill_rd && mem_gnt_i) begin
                        rd_pend <= 1'b1;
                        src_ptr <= src_ptr + A_ONE;
                        rem_src <= rem_src - RS_ONE;
                    end
                    if (slot_done) begin
                        buf_q[fill_idx] <= rd_pend ? mem_rdata_i : 64'd0;
                        rd_pend         <= 1'b0;
                        if (fill_idx == IDX_LAST) state <= refill ? S_FEED : S_KICK;
                        else                      fill_idx <= fill_idx + IDX_W'(1);
                    end
                end
                S_KICK:  state <= S_RUN;
                S_RUN: begin
                    if (asc_ct_ready_i) begin
                        state  <= S_DRAIN;
                        cnt    <= CNT_FULL;
                        wr_idx <= '0;
                    end else if (asc_done_i) begin
                        state  <= S_TAIL;
                        cnt    <= (int'(rem_ct) > BUF_DEPTH) ? CNT_FULL : CNT_W'(rem_ct);
                        wr_idx <= '0;
                    end else if (asc_data_req_i) begin
                        if (rem_src == '0) err <= 1'b1;
                        state    <= S_FILL;
                        fill_idx <= '0;
                        refill   <= 1'b1;
                    end
                end
                S_FEED:  state <= S_GUARD;
                S_GUARD: state <= S_RUN;
                S_ACK:   state <= S_GUARD;
                S_DRAIN, S_TAIL: begin
                    if (wr_idx == cnt) begin
                        state <= S_TAG0;
                    end else if (mem_gnt_i) begin
                        dst_ptr <= dst_ptr + A_ONE;
                        rem_ct  <= (rem_ct == '0) ? '0 : rem_ct - PT_ONE;
                        wr_idx  <= wr_idx + CNT_ONE;
                        if ((wr_idx + CNT_ONE) == cnt) state <= (state == S_DRAIN) ? S_ACK : S_TAG0;
                    end
                end
                S_TAG0: if (mem_gnt_i) begin
                    dst_ptr <= dst_ptr + A_ONE;
                    state   <= S_TAG1;
                end
                S_TAG1:  if (mem_gnt_i) state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ascon_mem_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_ascon_mem_sched: stub wrapper + stalling memory, checked against a stream model.
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_ascon_mem_sched;
    localparam int D   = 4;
    localparam int TMO = 600;
    localparam logic [63:0] KEY = 64'hA5C3_0F1E_9B2D_7C48;

    typedef struct {
        logic [15:0] src;
        logic [15:0] dst;
        int          ad;
        int          pt;
        bit          extra;
        bit          poke;
        int          stall;
        int          exp_rd;
        int          exp_wr;
        int          exp_dv;
        int          exp_ack;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cmd_start = 1'b0;
    logic [15:0]    src_base = '0, dst_base = '0;
    logic [2:0]     ad_size = '0, pt_size = '0;
    logic           busy, done, err;
    logic           mem_req, mem_we, mem_gnt;
    logic [15:0]    mem_addr;
    logic [63:0]    mem_wdata;
    logic           mem_rvalid = 1'b0;
    logic [63:0]    mem_rdata = '0;
    logic [D*64-1:0] asc_data;
    logic           asc_start, asc_dv, asc_ack;
    logic           asc_data_req = 1'b0, asc_ct_ready = 1'b0, asc_done = 1'b0;
    logic [D*64-1:0] asc_ct = '0;
    logic [127:0]   asc_tag = '0;

    ascon_mem_sched dut (
        .clk_i(clk), .rst_n_i(rst_n), .cmd_start_i(cmd_start),
        .src_base_i(src_base), .dst_base_i(dst_base),
        .ad_size_i(ad_size), .pt_size_i(pt_size),
        .busy_o(busy), .done_o(done), .err_o(err),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .asc_data_o(asc_data), .asc_start_o(asc_start),
        .asc_data_valid_o(asc_dv), .asc_ct_read_ack_o(asc_ack),
        .asc_data_req_i(asc_data_req), .asc_ct_ready_i(asc_ct_ready),
        .asc_done_i(asc_done), .asc_ct_i(asc_ct), .asc_tag_i(asc_tag)
    );

    always #5 clk = ~clk;

    // Memory: random grant stalls and random read latency (>= 1 cycle after gnt).
    logic [63:0] mem [0:65535];
    int          max_stall = 0;
    int          stall_left = 0;
    bit          rd_busy = 1'b0;
    int          rd_wait = 0;
    logic [63:0] rd_hold = '0;

    assign mem_gnt = mem_req && (stall_left == 0);

    always @(posedge clk) begin
        mem_rvalid <= 1'b0;
        if (!rst_n) begin
            stall_left <= 0;
            rd_busy    <= 1'b0;
        end else begin
            if (mem_req && !mem_gnt) begin
                stall_left <= stall_left - 1;
            end else if (mem_req) begin
                stall_left <= $urandom_range(max_stall, 0);
                if (!mem_we) begin
                    rd_busy <= 1'b1;
                    rd_wait <= $urandom_range(max_stall, 0);
                    rd_hold <= mem[mem_addr];
                end
            end
            if (rd_busy && rd_wait == 0) begin
                mem_rvalid <= 1'b1;
                mem_rdata  <= rd_hold;
                rd_busy    <= 1'b0;
            end else if (rd_busy) begin
                rd_wait <= rd_wait - 1;
            end
        end
    end

    int n_chk = 0, n_pass = 0;
    int n_start, n_dv, n_ack, n_done;
    logic [15:0] rd_a[$];
    logic [15:0] wr_a[$];
    logic [63:0] wr_d[$];
    bit          held = 1'b0;
    logic [81:0] held_val;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // One cycle: sample at the falling edge, log pulses and accepted transactions.
    task automatic tick();
        @(negedge clk);
        if (asc_start) n_start++;
        if (asc_dv)    n_dv++;
        if (asc_ack)   n_ack++;
        if (done)      n_done++;
        if (held) chk("req_stable", 128'({mem_req, mem_we, mem_addr, mem_wdata}), 128'(held_val));
        if (mem_req && mem_gnt) begin
            held = 1'b0;
            if (mem_we) begin
                wr_a.push_back(mem_addr);
                wr_d.push_back(mem_wdata);
                mem[mem_addr] = mem_wdata;
            end else begin
                rd_a.push_back(mem_addr);
            end
        end else if (mem_req) begin
            held     = 1'b1;
            held_val = {mem_req, mem_we, mem_addr, mem_wdata};
        end else begin
            held = 1'b0;
        end
    endtask

    task automatic wait_sig(input int sel, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < TMO && !hit; i++) begin
            tick();
            case (sel)
                0: hit = asc_start;
                1: hit = asc_dv;
                2: hit = asc_ack;
                3: hit = done;
                default: hit = mem_req && mem_we;
            endcase
        end
        if (!hit) begin
            n_chk++;
            $display("FAIL timeout_%s: got no event expected event within %0d cycles", name, TMO);
        end
    endtask

    task automatic pack_ct(input logic [63:0] q[$]);
        for (int j = 0; j < D; j++) asc_ct[j*64 +: 64] = (j < q.size()) ? q[j] : 64'd0;
    endtask

    task automatic run_cmd(input vec_t v);
        logic [63:0] srcw[$];
        logic [63:0] cap[$];
        logic [63:0] ctq[$];
        logic [63:0] blk[D];
        logic [15:0] ea[$];
        logic [63:0] ed[$];
        logic [63:0] w, lo, hi;
        int total, nb, nbuf, bad, pos;
        total = v.ad + v.pt;
        nb    = (total + D - 1) / D;
        nbuf  = nb + int'(v.extra);
        for (int i = 0; i < total; i++) begin
            w = {$urandom, $urandom};
            srcw.push_back(w);
            mem[16'(v.src + 16'(i))] = w;
        end
        max_stall = v.stall;
        rd_a.delete(); wr_a.delete(); wr_d.delete();
        n_start = 0; n_dv = 0; n_ack = 0; n_done = 0;
        src_base = v.src; dst_base = v.dst;
        ad_size = 3'(v.ad); pt_size = 3'(v.pt);
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        // Stub wrapper: consumes buffers, emits CT = PT ^ KEY, tag from all words seen.
        for (int k = 0; k < nbuf; k++) begin
            if (k == 0) wait_sig(0, "start");
            else begin
                asc_data_req = 1'b1;
                wait_sig(1, "refill");
                asc_data_req = 1'b0;
            end
            for (int j = 0; j < D; j++) blk[j] = asc_data[j*64 +: 64];
            if (k == 0 && v.poke) begin
                src_base = v.src ^ 16'h0700; ad_size = 3'd7; pt_size = 3'd7;
                cmd_start = 1'b1;
                tick();
                cmd_start = 1'b0;
                src_base = v.src; ad_size = 3'(v.ad); pt_size = 3'(v.pt);
            end
            for (int j = 0; j < D; j++) begin
                cap.push_back(blk[j]);
                pos = cap.size() - 1;
                if (pos >= v.ad && pos < total) begin
                    ctq.push_back(blk[j] ^ KEY);
                    if (ctq.size() == D) begin
                        pack_ct(ctq);
                        asc_ct_ready = 1'b1;
                        wait_sig(2, "ct_ack");
                        asc_ct_ready = 1'b0;
                        ctq.delete();
                    end
                end
            end
        end
        pack_ct(ctq);
        lo = '0; hi = '0;
        for (int i = 0; i < cap.size(); i++) begin
            lo = lo + cap[i] * 64'(i + 1);
            hi = hi ^ (cap[i] * 64'(2 * i + 3));
        end
        asc_tag  = {hi, lo};
        asc_done = 1'b1;
        wait_sig(3, "done");
        asc_done = 1'b0;
        asc_ct   = '0;
        tick(); tick();

        chk("start_pulses", 128'(n_start), 128'(1));
        chk("refill_pulses", 128'(n_dv), 128'(v.exp_dv));
        chk("ack_pulses", 128'(n_ack), 128'(v.exp_ack));
        chk("done_pulses", 128'(n_done), 128'(1));
        chk("err_flag", 128'(err), 128'(v.extra));
        chk("busy_after", 128'(busy), 128'(0));

        // Model: padded input stream, expected reads, expected write image.
        chk("cap_len", 128'(cap.size()), 128'(nbuf * D));
        bad = 0;
        for (int i = 0; i < cap.size(); i++) if (cap[i] !== ((i < total) ? srcw[i] : 64'd0)) bad++;
        chk("buffer_words", 128'(bad), 128'(0));
        chk("rd_count", 128'(rd_a.size()), 128'(v.exp_rd));
        bad = 0;
        for (int i = 0; i < rd_a.size(); i++) if (rd_a[i] !== 16'(v.src + 16'(i))) bad++;
        chk("rd_addrs", 128'(bad), 128'(0));
        lo = '0; hi = '0;
        for (int i = 0; i < total; i++) begin
            lo = lo + srcw[i] * 64'(i + 1);
            hi = hi ^ (srcw[i] * 64'(2 * i + 3));
        end
        for (int j = 0; j < v.pt; j++) begin
            ea.push_back(16'(v.dst + 16'(j)));
            ed.push_back(srcw[v.ad + j] ^ KEY);
        end
        ea.push_back(16'(v.dst + 16'(v.pt)));     ed.push_back(lo);
        ea.push_back(16'(v.dst + 16'(v.pt + 1))); ed.push_back(hi);
        chk("wr_count", 128'(wr_a.size()), 128'(v.exp_wr));
        bad = 0;
        for (int i = 0; i < wr_a.size() && i < ea.size(); i++)
            if (wr_a[i] !== ea[i] || wr_d[i] !== ed[i]) bad++;
        chk("wr_image", 128'(bad), 128'(0));
    endtask

    vec_t tbl[8];
    vec_t rv;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          src       dst       ad pt ex pk st rd wr dv ack
        tbl[0] = '{16'h0010, 16'h0040, 1, 1, 0, 0, 0, 2, 3, 0, 0};
        tbl[1] = '{16'h0010, 16'h0040, 3, 4, 0, 1, 0, 7, 6, 1, 1};
        tbl[2] = '{16'h0010, 16'h0040, 3, 4, 0, 0, 3, 7, 6, 1, 1};
        tbl[3] = '{16'h0080, 16'h00C0, 0, 1, 1, 0, 0, 1, 3, 1, 0};
        tbl[4] = '{16'h0100, 16'h0180, 7, 7, 0, 0, 2, 14, 9, 3, 1};
        tbl[5] = '{16'hFFFD, 16'h7FFE, 2, 3, 0, 0, 1, 5, 5, 1, 0};
        tbl[6] = '{16'h0020, 16'h0060, 0, 4, 0, 0, 0, 4, 6, 0, 1};
        tbl[7] = '{16'h0030, 16'h0090, 5, 7, 1, 1, 1, 12, 9, 3, 1};

        repeat (3) tick();
        chk("reset_ctl", 128'({busy, done, err, mem_req, mem_we, asc_start, asc_dv, asc_ack}), 128'(0));
        chk("reset_data", 128'((|asc_data) | (|mem_addr) | (|mem_wdata)), 128'(0));
        rst_n = 1'b1;
        tick();

        for (int t = 0; t < 8; t++) run_cmd(tbl[t]);

        for (int t = 0; t < 10; t++) begin
            rv.ad    = $urandom_range(7, 0);
            rv.pt    = $urandom_range(7, 1);
            rv.src   = 16'($urandom);
            rv.dst   = rv.src ^ 16'h8000;
            rv.extra = 1'($urandom);
            rv.poke  = 1'($urandom);
            rv.stall = $urandom_range(3, 0);
            rv.exp_rd  = rv.ad + rv.pt;
            rv.exp_wr  = rv.pt + 2;
            rv.exp_dv  = (rv.ad + rv.pt + D - 1) / D - 1 + int'(rv.extra);
            rv.exp_ack = rv.pt / D;
            run_cmd(rv);
        end

        // Spurious refill sets err, then reset lands in the middle of a drain.
        max_stall = 0;
        mem[16'h0200] = 64'h1111_2222_3333_4444;
        src_base = 16'h0200; dst_base = 16'h0300; ad_size = 3'd0; pt_size = 3'd1;
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        wait_sig(0, "rst_start");
        asc_data_req = 1'b1;
        wait_sig(1, "rst_refill");
        asc_data_req = 1'b0;
        tick();
        chk("err_set", 128'(err), 128'(1));
        asc_ct = {4{64'hDEAD_BEEF_0000_0001}};
        asc_ct_ready = 1'b1;
        wait_sig(4, "drain_write");
        rst_n = 1'b0;
        held  = 1'b0;
        tick();
        chk("rst_mid_ctl", 128'({busy, done, err, mem_req, mem_we, asc_start, asc_dv, asc_ack}), 128'(0));
        chk("rst_mid_data", 128'((|asc_data) | (|mem_addr) | (|mem_wdata)), 128'(0));
        rst_n = 1'b1;
        asc_ct_ready = 1'b0;
        asc_ct = '0;
        n_done = 0;
        repeat (20) tick();
        chk("no_done_after_rst", 128'(n_done), 128'(0));
        chk("idle_after_rst", 128'(busy), 128'(0));
        run_cmd('{16'h0400, 16'h0500, 1, 2, 0, 0, 1, 3, 4, 0, 0});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
